// File: rtl/apb_slave_mem_if.sv
// APB bus bundle (4-bit address, 8-bit data) between one master and one completer.
// The master modport drives the request side; the slave modport drives the response.
interface apb_slave_mem_if;
  logic       Psel;
  logic       Penable;
  logic       Pwrite;
  logic [3:0] Paddr;
  logic [7:0] PWdata;
  logic [7:0] PRdata;
  logic       Pready;
  logic       Pslverr;

  modport master (
    output Psel, Penable, Pwrite, Paddr, PWdata,
    input  PRdata, Pready, Pslverr
  );

  modport slave (
    input  Psel, Penable, Pwrite, Paddr, PWdata,
    output PRdata, Pready, Pslverr
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer holding a 16x8 register file; addresses >= ADDR_LIMIT answer with Pslverr.
// Define APB_SLAVE_WAIT_EN to stretch every transfer by WAIT_CYCLES wait states.
module apb_slave_mem #(
  parameter int unsigned ADDR_LIMIT  = 12,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic             Pclk,
  input logic             Presetn,
  apb_slave_mem_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e     state_q, state_d;
  logic [7:0] mem_q [16];
  logic [7:0] mem_d [16];

  logic in_xfer;
  logic active;
  logic cnt_zero;
  logic complete;
  logic addr_err;

  assign in_xfer  = (state_q == SETUP) || (state_q == ACCESS);
  assign active   = bus.Psel & bus.Penable & in_xfer;
  assign complete = active & cnt_zero;
  assign addr_err = (32'(bus.Paddr) >= ADDR_LIMIT);

`ifdef APB_SLAVE_WAIT_EN
  localparam logic [2:0] WAIT_LOAD = WAIT_CYCLES[2:0];

  logic [2:0] cnt_q, cnt_d;

  // Counter is armed by every setup phase and drains one step per Penable cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.Psel && !bus.Penable) begin
      cnt_d = WAIT_LOAD;
    end else if (active && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_zero = (cnt_q == 3'd0);
`else
  logic unused_wait_cfg;

  assign unused_wait_cfg = ^WAIT_CYCLES;
  assign cnt_zero        = 1'b1;
`endif

  // SETUP means a setup phase was seen; a completed transfer always returns to IDLE,
  // so a back-to-back setup phase re-enters SETUP on the following edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Psel && !bus.Penable) state_d = SETUP;
      end
      SETUP: begin
        if (!bus.Psel) begin
          state_d = IDLE;
        end else if (bus.Penable) begin
          state_d = cnt_zero ? IDLE : ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.Psel || !bus.Penable || cnt_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (complete && bus.Pwrite && !addr_err) begin
      mem_d[bus.Paddr] = bus.PWdata;
    end
  end

  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      state_q <= IDLE;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.Pready  = complete;
  assign bus.Pslverr = complete & addr_err;
  assign bus.PRdata  = (complete && !bus.Pwrite && !addr_err) ? mem_q[bus.Paddr] : 8'h00;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed self-checking bench for apb_slave_mem; wait-state expectations follow APB_SLAVE_WAIT_EN.
module tb_apb_slave_mem;

`ifdef APB_SLAVE_WAIT_EN
  localparam logic [7:0] EXP_WAITS = 8'd2;
`else
  localparam logic [7:0] EXP_WAITS = 8'd0;
`endif

  logic Pclk;
  logic Presetn;
  int   passed;
  int   failed;
  int   total;

  logic [7:0] rdata;
  logic       rerr;
  logic [7:0] waits;

  apb_slave_mem_if bus ();

  apb_slave_mem #(.ADDR_LIMIT(12), .WAIT_CYCLES(2)) dut (
    .Pclk    (Pclk),
    .Presetn (Presetn),
    .bus     (bus)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transfer: setup phase, then Penable held until Pready (bounded).
  task automatic applyStimulus(input logic wr, input logic [3:0] addr, input logic [7:0] data,
                               output logic [7:0] rd, output logic err, output logic [7:0] nwait);
    @(posedge Pclk); #1;
    bus.Psel    = 1'b1;
    bus.Penable = 1'b0;
    bus.Pwrite  = wr;
    bus.Paddr   = addr;
    bus.PWdata  = data;
    @(negedge Pclk);
    checkOutput("setup_pready_low", {7'b0, bus.Pready}, 8'h00);
    @(posedge Pclk); #1;
    bus.Penable = 1'b1;
    nwait = 8'd0;
    forever begin
      @(negedge Pclk);
      if (bus.Pready === 1'b1) break;
      nwait++;
      if (nwait > 8'd20) break;
    end
    rd  = bus.PRdata;
    err = bus.Pslverr;
  endtask

  task automatic goIdle();
    @(posedge Pclk); #1;
    bus.Psel    = 1'b0;
    bus.Penable = 1'b0;
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    Presetn     = 1'b0;
    bus.Psel    = 1'b0;
    bus.Penable = 1'b0;
    bus.Pwrite  = 1'b0;
    bus.Paddr   = 4'h0;
    bus.PWdata  = 8'h00;

    repeat (2) @(posedge Pclk);
    @(negedge Pclk);
    checkOutput("reset_pready", {7'b0, bus.Pready}, 8'h00);
    checkOutput("reset_pslverr", {7'b0, bus.Pslverr}, 8'h00);
    checkOutput("reset_prdata", bus.PRdata, 8'h00);
    Presetn = 1'b1;

    applyStimulus(1'b0, 4'h3, 8'h00, rdata, rerr, waits);
    checkOutput("rd3_waits", waits, EXP_WAITS);
    checkOutput("rd3_data", rdata, 8'h00);
    checkOutput("rd3_err", {7'b0, rerr}, 8'h00);
    goIdle();

    applyStimulus(1'b1, 4'h2, 8'hA5, rdata, rerr, waits);
    checkOutput("wr2_err", {7'b0, rerr}, 8'h00);
    checkOutput("wr2_prdata_zero", rdata, 8'h00);
    goIdle();
    applyStimulus(1'b0, 4'h2, 8'h00, rdata, rerr, waits);
    checkOutput("rd2_data", rdata, 8'hA5);
    goIdle();
    applyStimulus(1'b0, 4'h3, 8'h00, rdata, rerr, waits);
    checkOutput("rd3_untouched", rdata, 8'h00);
    goIdle();

    applyStimulus(1'b1, 4'hE, 8'h5A, rdata, rerr, waits);
    checkOutput("wrE_err", {7'b0, rerr}, 8'h01);
    goIdle();
    applyStimulus(1'b0, 4'hE, 8'h00, rdata, rerr, waits);
    checkOutput("rdE_data", rdata, 8'h00);
    checkOutput("rdE_err", {7'b0, rerr}, 8'h01);
    goIdle();

    applyStimulus(1'b1, 4'hB, 8'h3C, rdata, rerr, waits);
    checkOutput("wrB_err", {7'b0, rerr}, 8'h00);
    goIdle();
    applyStimulus(1'b0, 4'hB, 8'h00, rdata, rerr, waits);
    checkOutput("rdB_data", rdata, 8'h3C);
    checkOutput("rdB_err", {7'b0, rerr}, 8'h00);
    goIdle();
    applyStimulus(1'b1, 4'hC, 8'hC3, rdata, rerr, waits);
    checkOutput("wrC_err", {7'b0, rerr}, 8'h01);
    goIdle();

    applyStimulus(1'b1, 4'h1, 8'h11, rdata, rerr, waits);
    checkOutput("b2b_wr1_waits", waits, EXP_WAITS);
    applyStimulus(1'b1, 4'h2, 8'h22, rdata, rerr, waits);
    checkOutput("b2b_wr2_waits", waits, EXP_WAITS);
    applyStimulus(1'b0, 4'h1, 8'h00, rdata, rerr, waits);
    checkOutput("b2b_rd1", rdata, 8'h11);
    applyStimulus(1'b0, 4'h2, 8'h00, rdata, rerr, waits);
    checkOutput("b2b_rd2", rdata, 8'h22);
    goIdle();

    @(posedge Pclk); #1;
    bus.Psel    = 1'b0;
    bus.Penable = 1'b1;
    bus.Pwrite  = 1'b1;
    bus.Paddr   = 4'h3;
    bus.PWdata  = 8'hFF;
    @(negedge Pclk);
    checkOutput("nosel_pready", {7'b0, bus.Pready}, 8'h00);
    checkOutput("nosel_prdata", bus.PRdata, 8'h00);
    goIdle();
    applyStimulus(1'b0, 4'h3, 8'h00, rdata, rerr, waits);
    checkOutput("nosel_mem3", rdata, 8'h00);
    goIdle();

    applyStimulus(1'b1, 4'h0, 8'h77, rdata, rerr, waits);
    checkOutput("wr0_waits", waits, EXP_WAITS);
    goIdle();
    applyStimulus(1'b0, 4'h0, 8'h00, rdata, rerr, waits);
    checkOutput("rd0_data", rdata, 8'h77);
    goIdle();

    @(posedge Pclk); #1;
    bus.Psel    = 1'b1;
    bus.Penable = 1'b0;
    bus.Pwrite  = 1'b1;
    bus.Paddr   = 4'h5;
    bus.PWdata  = 8'hFF;
    @(posedge Pclk); #1;
    bus.Penable = 1'b1;
    @(negedge Pclk);
    Presetn = 1'b0;
    #1;
    checkOutput("rst_mid_pready", {7'b0, bus.Pready}, 8'h00);
    @(posedge Pclk); #1;
    bus.Psel    = 1'b0;
    bus.Penable = 1'b0;
    @(negedge Pclk);
    Presetn = 1'b1;
    applyStimulus(1'b0, 4'h5, 8'h00, rdata, rerr, waits);
    checkOutput("rst_mid_mem5", rdata, 8'h00);
    goIdle();
    applyStimulus(1'b0, 4'h2, 8'h00, rdata, rerr, waits);
    checkOutput("rst_cleared_mem2", rdata, 8'h00);
    goIdle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
